// File: rtl/rng_pkg.sv
// Shared defaults and counter-width helper for the random-bit collector.
package rng_pkg;

  localparam int unsigned WORD_W_DEF      = 64;
  localparam int unsigned REP_LIMIT_DEF   = 32;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned BIT_CNT_W_DEF = cnt_w(WORD_W_DEF);
  localparam int unsigned REP_CNT_W_DEF = cnt_w(REP_LIMIT_DEF + 1);

endpackage

// File: rtl/rng_sync_edge.sv
// Synchronizes the slow source strobe/data into the system clock and
// produces a one-cycle registered strobe per source rising edge.
module rng_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rng_clk,
  input  logic rng_data,
  output logic raw_strobe,
  output logic raw_bit
);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   prev;

  // Data travels through the same depth as the strobe so both line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      prev       <= 1'b0;
      raw_strobe <= 1'b0;
      raw_bit    <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], rng_clk};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], rng_data};
      prev       <= clk_sync[SYNC_STAGES-1];
      raw_strobe <= clk_sync[SYNC_STAGES-1] & ~prev;
      raw_bit    <= data_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/rng_bit_collector.sv
// Collects source bits: repetition health test, optional von Neumann
// debias, word packing and a valid/ready output register.
module rng_bit_collector
  import rng_pkg::*;
#(
  parameter int unsigned WORD_W      = WORD_W_DEF,
  parameter int unsigned REP_LIMIT   = REP_LIMIT_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk_jbus,
  input  logic              rst,
  input  logic              rng_clk,
  input  logic              rng_data,
  input  logic              en,
  input  logic              debias_en,
  input  logic              word_ready,
  input  logic              clr_err,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data,
  output logic              ovfl,
  output logic              stuck_err
);

  localparam int unsigned CNT_W = cnt_w(WORD_W);
  localparam int unsigned REP_W = cnt_w(REP_LIMIT + 1);

  logic              raw_strobe;
  logic              raw_bit;
  logic              debias_mode;
  logic              last_bit;
  logic [REP_W-1:0]  rep_cnt;
  logic              pair_vld;
  logic              pair_bit;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  logic              take_c;
  logic [REP_W-1:0]  rep_next_c;
  logic              stuck_set_c;
  logic              emit_c;
  logic              emit_bit_c;
  logic              pack_c;
  logic              complete_c;
  logic [WORD_W-1:0] new_word_c;
  logic              load_c;
  logic              drop_c;

  rng_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk        (clk_jbus),
    .rst        (rst),
    .rng_clk    (rng_clk),
    .rng_data   (rng_data),
    .raw_strobe (raw_strobe),
    .raw_bit    (raw_bit)
  );

  always_comb begin
    take_c      = en & raw_strobe;
    rep_next_c  = rep_cnt;
    emit_c      = 1'b0;
    emit_bit_c  = raw_bit;

    // Run length restarts on a new value (or the first bit after enable).
    if (rep_cnt == '0 || raw_bit != last_bit) begin
      rep_next_c = REP_W'(1);
    end else if (rep_cnt != REP_W'(REP_LIMIT)) begin
      rep_next_c = rep_cnt + 1'b1;
    end
    stuck_set_c = take_c & (rep_next_c == REP_W'(REP_LIMIT));

    if (take_c) begin
      if (debias_mode) begin
        emit_c     = pair_vld & (pair_bit ^ raw_bit);
        emit_bit_c = pair_bit;
      end else begin
        emit_c = 1'b1;
      end
    end

    pack_c     = emit_c & ~stuck_err;
    complete_c = pack_c & (bit_cnt == CNT_W'(WORD_W - 1));
    new_word_c = {shreg[WORD_W-2:0], emit_bit_c};
    load_c     = complete_c & (~word_valid | word_ready);
    drop_c     = complete_c & word_valid & ~word_ready;
  end

  always_ff @(posedge clk_jbus) begin
    if (rst) begin
      debias_mode <= 1'b0;
      last_bit    <= 1'b0;
      rep_cnt     <= '0;
      pair_vld    <= 1'b0;
      pair_bit    <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      ovfl        <= 1'b0;
      stuck_err   <= 1'b0;
    end else begin
      if (!en) begin
        debias_mode <= debias_en;
        bit_cnt     <= '0;
        pair_vld    <= 1'b0;
        rep_cnt     <= '0;
      end else if (raw_strobe) begin
        rep_cnt  <= rep_next_c;
        last_bit <= raw_bit;
        if (debias_mode) begin
          pair_vld <= ~pair_vld;
          if (!pair_vld) pair_bit <= raw_bit;
        end
        if (pack_c) begin
          shreg   <= new_word_c;
          bit_cnt <= complete_c ? '0 : bit_cnt + 1'b1;
        end
      end

      // A completing word may replace one being consumed this same cycle.
      if (load_c) begin
        word_data  <= new_word_c;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      ovfl      <= drop_c | (ovfl & ~clr_err);
      stuck_err <= stuck_set_c | (stuck_err & ~clr_err);
    end
  end

endmodule

// File: doc/rng_bit_collector.md
# rng_bit_collector

Downstream consumer of the analog random-bit source. Samples the source's slow `rng_clk`/`rng_data` pair as ordinary data in the `clk_jbus` domain, detects source clock rising edges, optionally von-Neumann-debiases the raw bits, and packs them into `WORD_W`-bit words. Words go to the register/IO side over a valid/ready handshake. A repetition-count health test flags a stuck source.

## Interface
Parameters:
- `WORD_W`, 64, output word width; must be ≥ 2.
- `REP_LIMIT`, 32, consecutive identical raw bits that set `stuck_err`; must be ≥ 2.
- `SYNC_STAGES`, 2, synchronizer depth for `rng_clk` and `rng_data`; must be ≥ 2.

Ports:
- `clk_jbus`  in  1  system clock; the only clock of the block.
- `rst`  in  1  reset; synchronous, active-high.
- `rng_clk`  in  1  source strobe; asynchronous to `clk_jbus`; much slower.
- `rng_data`  in  1  source bit; changes together with `rng_clk`.
- `en`  in  1  collection enable.
- `debias_en`  in  1  von Neumann debias enable; sample it only while `en` = 0.
- `word_ready`  in  1  consumer accepts the word.
- `clr_err`  in  1  clears `ovfl` and `stuck_err`.
- `word_valid`  out  1  `word_data` holds an unconsumed word.
- `word_data`  out  WORD_W  packed random word.
- `ovfl`  out  1  sticky flag: a completed word was dropped.
- `stuck_err`  out  1  sticky flag: repetition limit reached.

## Operation
- Synchronize `rng_clk` and `rng_data` through `SYNC_STAGES` flops each. One more flop on the synced clock gives `prev`. `raw_strobe` = synced clock & ~`prev`. `raw_bit` = synced data in the same stage.
- Repetition test runs on every `raw_strobe` while `en` = 1:
  - `rep_cnt` holds the run length of the current value.
  - It resets to 1 when the bit differs from the last raw bit, and increments otherwise, saturating at `REP_LIMIT`.
  - When `rep_cnt` reaches `REP_LIMIT`, set `stuck_err`.
- Debias, when `debias_en` = 1:
  - Raw bits form pairs. The first bit of a pair is held in `pair_bit`/`pair_vld`.
  - On the second bit: pairs 01 and 10 emit the first bit; pairs 00 and 11 emit nothing.
  - `pair_vld` clears either way.
- When `debias_en` = 0, every `raw_bit` is emitted.
- Packing:
  - An emitted bit shifts into `shreg` at bit 0 (`shreg <= {shreg[WORD_W-2:0], bit}`), so the earliest bit ends at the MSB.
  - `bit_cnt` runs 0..WORD_W-1.
  - On the WORD_W-th bit the word is complete and `bit_cnt` wraps to 0.
- Output register on word completion:
  - If `word_valid` = 0, or `word_valid & word_ready` in the same cycle: load `word_data`, set `word_valid`.
  - Otherwise drop the word, set `ovfl`, and leave `word_data` unchanged.
- `word_valid & word_ready` with no completion: clear `word_valid`. `word_data` holds its last value.
- While `stuck_err` = 1, emitted bits are discarded. The health test keeps running.
- `en` = 0:
  - Strobes are ignored.
  - `bit_cnt`, `pair_vld` and `rep_cnt` clear.
  - The output register and its handshake are unaffected.
- `clr_err` clears both sticky flags. A set in the same cycle wins over the clear.

## Timing
- Reset values: `word_valid` = 0, `word_data` = 0, `ovfl` = 0, `stuck_err` = 0. All synchronizers, `prev`, `bit_cnt`, `pair_vld` and `rep_cnt` are 0 on the cycle after `rst` is sampled high.
- Reset mid-word discards the partial word and any pending output word.
- Latency, with `SYNC_STAGES` = 2:
  - `rng_clk` first sampled high at edge N gives `raw_strobe` in cycle N+2.
  - `shreg`/`bit_cnt` update at edge N+3.
  - Completing the word on that strobe gives `word_valid` = 1 from edge N+3.
  - In general: `SYNC_STAGES`+1 edges from the first high sample to update.
- Each rising edge of `rng_clk` yields exactly one `raw_strobe`, provided `rng_clk` stays high and low for ≥ `SYNC_STAGES`+1 `clk_jbus` cycles each.
- Handshake:
  - `word_data` is stable while `word_valid` = 1 and `word_ready` = 0.
  - `word_ready` with `word_valid` = 0 has no effect.
  - Back-to-back words are accepted with no bubble when ready is held.

## Structure
- Package `rng_pkg`: default `WORD_W`/`REP_LIMIT`/`SYNC_STAGES` constants and `$clog2`-derived counter widths.
- Sub-module `rng_sync_edge`: parameterized synchronizer for clock and data, plus the `prev` flop. Outputs `raw_strobe` and `raw_bit`.
- Top-level holds the health test, debias, packer and output register.

## Test plan
- Reset, then `en` = 1, `debias_en` = 0, `word_ready` = 1, `WORD_W` = 8, bits 1,0,1,1,0,0,1,0 -> `word_data` = 8'hB2, `word_valid` high for 1 cycle, with the latency above.
- `debias_en` = 1, raw pairs 01,11,10,00 ×4 -> 8 emitted bits, alternating starting with 0 (01→0, 10→1, 11/00 emit nothing) -> `word_data` = 8'h55.
- `word_ready` = 0 across two word completions -> first word held; `ovfl` = 1 at the second completion; `word_data` unchanged; `clr_err` clears `ovfl`.
- Completion in the same cycle as `word_valid & word_ready` -> new word loaded, `word_valid` stays 1, `ovfl` stays 0.
- 32 consecutive raw 1s -> `stuck_err` = 1 on the 32nd strobe; further bits not packed; `clr_err` -> collection resumes with a fresh count.
- Assert `rst` with `bit_cnt` = 5 and `word_valid` = 1 -> all outputs 0 next cycle; the next word starts from bit 0.
